// File: rtl/tmds_pkg.sv
// Shared types and constants for the TMDS encoder: control codes, TERC4 table,
// symbol and disparity types, and the popcount helper.
package tmds_pkg;

    localparam int C_CNT_WIDTH = 5;

    typedef logic [9:0] symbol_t;
    typedef logic signed [C_CNT_WIDTH-1:0] disp_t;

    localparam symbol_t CTRL_00 = 10'b1101010100;
    localparam symbol_t CTRL_01 = 10'b0010101011;
    localparam symbol_t CTRL_10 = 10'b0101010100;
    localparam symbol_t CTRL_11 = 10'b1010101011;

    // TERC4 codes for data-island periods, indexed by the 4-bit aux nibble.
    localparam symbol_t TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic symbol_t ctrl_code(input logic [1:0] c);
        symbol_t code;
        case (c)
            2'b00:   code = CTRL_00;
            2'b01:   code = CTRL_01;
            2'b10:   code = CTRL_10;
            default: code = CTRL_11;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] ones;
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, v[i]};
        end
        return ones;
    endfunction

endpackage

// File: rtl/tmds_qm.sv
// Combinational front end: expands the colour to 8 bits and produces the
// transition-minimised q_m word plus its ones count.
module tmds_qm
    import tmds_pkg::*;
#(
    parameter int C_depth = 8
) (
    input  logic [C_depth-1:0] data,
    output logic [8:0]         qm,
    output logic [3:0]         n1q
);

    logic [7:0] d8;
    logic [3:0] n1d;
    logic       use_xnor;

    // MSB-first replication of a narrow colour value into 8 bits.
    always_comb begin
        d8 = '0;
        for (int i = 0; i < 8; i++) begin
            d8[7-i] = data[C_depth-1-(i % C_depth)];
        end
    end

    always_comb begin
        n1d      = popcount8(d8);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d8[0]);
        qm       = '0;
        qm[0]    = d8[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d8[i]) : (qm[i-1] ^ d8[i]);
        end
        qm[8] = ~use_xnor;
        n1q   = popcount8(qm[7:0]);
    end

endmodule

// File: rtl/tmds_encoder.sv
// Two-stage TMDS 8b/10b encoder for one colour channel with running disparity.
// Define TMDS_TERC4_EN to add island/aux ports and TERC4 data-island coding.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int C_depth     = 8,
    parameter int C_cnt_width = C_CNT_WIDTH
) (
    input  logic               clk_pixel,
    input  logic               rst_n,
    input  logic [C_depth-1:0] data,
    input  logic [1:0]         c,
    input  logic               de,
`ifdef TMDS_TERC4_EN
    input  logic               island,
    input  logic [3:0]         aux,
`endif
    output symbol_t            tmds
);

    typedef logic signed [C_cnt_width-1:0] cnt_t;

    localparam cnt_t ZERO  = '0;
    localparam cnt_t TWO   = cnt_t'(2);
    localparam cnt_t EIGHT = cnt_t'(8);

    logic [8:0] qm_w;
    logic [3:0] n1q_w;

    logic [8:0] qm_d,  qm_q;
    logic [3:0] n1q_d, n1q_q;
    logic [1:0] c_d,   c_q;
    logic       de_d,  de_q;
`ifdef TMDS_TERC4_EN
    logic       island_d, island_q;
    logic [3:0] aux_d,    aux_q;
`endif

    symbol_t tmds_d, tmds_q;
    cnt_t    cnt_d,  cnt_q;

    cnt_t n1_s;
    cnt_t diff;
    logic diff_pos, diff_neg;
    logic cnt_zero, cnt_pos, cnt_neg;

    tmds_qm #(
        .C_depth (C_depth)
    ) u_qm (
        .data (data),
        .qm   (qm_w),
        .n1q  (n1q_w)
    );

    always_comb begin
        qm_d  = qm_w;
        n1q_d = n1q_w;
        c_d   = c;
        de_d  = de;
`ifdef TMDS_TERC4_EN
        island_d = island;
        aux_d    = aux;
`endif
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            qm_q  <= '0;
            n1q_q <= '0;
            c_q   <= '0;
            de_q  <= 1'b0;
`ifdef TMDS_TERC4_EN
            island_q <= 1'b0;
            aux_q    <= '0;
`endif
        end else begin
            qm_q  <= qm_d;
            n1q_q <= n1q_d;
            c_q   <= c_d;
            de_q  <= de_d;
`ifdef TMDS_TERC4_EN
            island_q <= island_d;
            aux_q    <= aux_d;
`endif
        end
    end

    // diff = n1q - n0q = 2*n1q - 8; signs derived from n1q avoid signed compares.
    always_comb begin
        n1_s     = cnt_t'(n1q_q);
        diff     = n1_s + n1_s - EIGHT;
        diff_pos = n1q_q > 4'd4;
        diff_neg = n1q_q < 4'd4;
        cnt_zero = cnt_q == ZERO;
        cnt_neg  = cnt_q[C_cnt_width-1];
        cnt_pos  = !cnt_zero && !cnt_neg;
    end

    always_comb begin
        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        if (de_q) begin
            if (cnt_zero || (!diff_pos && !diff_neg)) begin
                tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
                tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d  = cnt_q + (qm_q[8] ? TWO : ZERO) - diff;
            end else begin
                tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d  = cnt_q - (qm_q[8] ? ZERO : TWO) + diff;
            end
        end else begin
            cnt_d = ZERO;
`ifdef TMDS_TERC4_EN
            tmds_d = island_q ? TERC4_TABLE[aux_q] : ctrl_code(c_q);
`else
            tmds_d = ctrl_code(c_q);
`endif
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            tmds_q <= CTRL_00;
            cnt_q  <= ZERO;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: an 8-bit and a 3-bit instance driven in
// parallel and compared with an integer-level TMDS reference model.
module tb_tmds_encoder;

    logic       clk_pixel = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] data8     = '0;
    logic [2:0] data3     = '0;
    logic [1:0] c         = '0;
    logic       de        = 1'b0;
    logic [9:0] tmds8;
    logic [9:0] tmds3;
`ifdef TMDS_TERC4_EN
    logic       island    = 1'b0;
    logic [3:0] aux       = '0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [9:0] pend8, pend3;
    int         pendCnt8, pendCnt3;

    always #5 clk_pixel = ~clk_pixel;

    tmds_encoder #(.C_depth(8)) dut8 (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .data      (data8),
        .c         (c),
        .de        (de),
`ifdef TMDS_TERC4_EN
        .island    (island),
        .aux       (aux),
`endif
        .tmds      (tmds8)
    );

    tmds_encoder #(.C_depth(3)) dut3 (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .data      (data3),
        .c         (c),
        .de        (de),
`ifdef TMDS_TERC4_EN
        .island    (island),
        .aux       (aux),
`endif
        .tmds      (tmds3)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                     tag, actual, actual, expected, expected, $time);
        end
    endtask

    function automatic logic [7:0] expand3(input logic [2:0] d);
        logic [8:0] rep;
        rep = {d, d, d};
        return rep[8:1];
    endfunction

    function automatic int countOnes(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic refEncode(input logic [7:0] d, input logic dv, input logic [1:0] cc,
                             input int cntIn, output logic [9:0] sym, output int cntOut);
        logic [7:0] qm;
        int         n1, ones, zeros, qm8;
        logic       useXnor;
        if (!dv) begin
            case (cc)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            cntOut = 0;
        end else begin
            n1      = countOnes(d);
            useXnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0]   = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm8   = useXnor ? 0 : 1;
            ones  = countOnes(qm);
            zeros = 8 - ones;
            if (cntIn == 0 || ones == zeros) begin
                sym    = {qm8 == 0, qm8 == 1, (qm8 == 1) ? qm : ~qm};
                cntOut = cntIn + ((qm8 == 1) ? (ones - zeros) : (zeros - ones));
            end else if ((cntIn > 0 && ones > zeros) || (cntIn < 0 && zeros > ones)) begin
                sym    = {1'b1, qm8 == 1, ~qm};
                cntOut = cntIn + 2 * qm8 + (zeros - ones);
            end else begin
                sym    = {1'b0, qm8 == 1, qm};
                cntOut = cntIn - 2 * (1 - qm8) + (ones - zeros);
            end
        end
    endtask

    task automatic resetModel();
        pend8    = 10'h354;
        pend3    = 10'h354;
        pendCnt8 = 0;
        pendCnt3 = 0;
    endtask

    // Drives one pixel, advances a clock, and checks the symbol from the previous pixel.
    task automatic applyStimulus(input logic [7:0] d8, input logic [2:0] d3,
                                 input logic dv, input logic [1:0] cc);
        logic [9:0] nsym8, nsym3;
        int         ncnt8, ncnt3;
        data8 = d8;
        data3 = d3;
        de    = dv;
        c     = cc;
        refEncode(d8, dv, cc, pendCnt8, nsym8, ncnt8);
        refEncode(expand3(d3), dv, cc, pendCnt3, nsym3, ncnt3);
        @(posedge clk_pixel);
        #1;
        checkOutput("tmds8", int'(tmds8), int'(pend8));
        checkOutput("cnt8", int'(dut8.cnt_q), pendCnt8);
        checkOutput("tmds3", int'(tmds3), int'(pend3));
        checkOutput("cnt3", int'(dut3.cnt_q), pendCnt3);
        checkOutput("cnt8_range", int'(int'(dut8.cnt_q) >= -10 && int'(dut8.cnt_q) <= 10), 1);
        pend8    = nsym8;
        pend3    = nsym3;
        pendCnt8 = ncnt8;
        pendCnt3 = ncnt3;
    endtask

    initial begin
        int         runLeft;
        logic       runDe;
        logic [31:0] r;

        resetModel();
        repeat (3) @(posedge clk_pixel);
        #1;
        checkOutput("rst_tmds", int'(tmds8), 10'h354);
        checkOutput("rst_cnt", int'(dut8.cnt_q), 0);
        @(negedge clk_pixel);
        rst_n = 1'b1;

        applyStimulus(8'h00, 3'b000, 1'b0, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b00);
        checkOutput("post_rst_tmds", int'(tmds8), 10'h354);

        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        checkOutput("zero_a", int'(tmds8), 10'h100);
        checkOutput("zero_a_cnt", int'(dut8.cnt_q), -8);
        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        checkOutput("zero_b", int'(tmds8), 10'h3FF);
        checkOutput("zero_b_cnt", int'(dut8.cnt_q), 2);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b11);
        checkOutput("zero_c", int'(tmds8), 10'h100);
        checkOutput("zero_c_cnt", int'(dut8.cnt_q), -6);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b11);
        checkOutput("ctrl11_cnt", int'(dut8.cnt_q), 0);

        applyStimulus(8'hFF, 3'b111, 1'b1, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b11);
        checkOutput("ff_tmds", int'(tmds8), 10'h200);
        checkOutput("ff_cnt", int'(dut8.cnt_q), -8);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b11);
        checkOutput("ctrl11_tmds", int'(tmds8), 10'h2AB);
        checkOutput("ctrl11_cnt0", int'(dut8.cnt_q), 0);

        applyStimulus(8'h92, 3'b100, 1'b1, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b00);
        checkOutput("exp_d8", int'(tmds8), 10'h18E);
        checkOutput("exp_d3", int'(tmds3), 10'h18E);

        // Reset in the middle of an active run with nonzero disparity.
        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tmds8", int'(tmds8), 10'h354);
        checkOutput("midrst_cnt8", int'(dut8.cnt_q), 0);
        checkOutput("midrst_tmds3", int'(tmds3), 10'h354);
        @(negedge clk_pixel);
        rst_n = 1'b1;
        resetModel();
        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b1, 2'b00);
        checkOutput("midrst_first", int'(tmds8), 10'h100);

        runLeft = 0;
        runDe   = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (runLeft == 0) begin
                runDe   = ~runDe;
                runLeft = (n < 200) ? 1 : int'($urandom_range(1, 24));
            end
            runLeft--;
            r = $urandom;
            applyStimulus(r[7:0], r[10:8], runDe, r[12:11]);
        end
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b00);
        applyStimulus(8'h00, 3'b000, 1'b0, 2'b00);

`ifdef TMDS_TERC4_EN
        de     = 1'b0;
        island = 1'b1;
        aux    = 4'h0;
        @(posedge clk_pixel);
        #1;
        aux = 4'hF;
        @(posedge clk_pixel);
        #1;
        checkOutput("terc4_0", int'(tmds8), 10'h29C);
        island = 1'b0;
        c      = 2'b01;
        @(posedge clk_pixel);
        #1;
        checkOutput("terc4_f", int'(tmds8), 10'h2C3);
        checkOutput("terc4_cnt", int'(dut8.cnt_q), 0);
        @(posedge clk_pixel);
        #1;
        checkOutput("terc4_ctrl01", int'(tmds8), 10'h0AB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
